// File: rtl/stack_level_if.sv
// Handshake bundle between the stacker level controller (master) and the
// row datapath / display (slave). Optional best_level member under BEST_LEVEL_EN.
interface stack_level_if #(
  parameter int unsigned LEVEL_W  = 6,
  parameter int unsigned SPEED_W  = 11,
  parameter int unsigned BLOCKS_W = 4
);
  logic                go;
  logic                next_signal;
  logic                miss;
  logic                drop_pulse;
  logic [SPEED_W-1:0]  speed_count;
  logic [BLOCKS_W-1:0] num_blocks;
  logic [LEVEL_W-1:0]  curr_level;
  logic                game_over;
  logic                win;
`ifdef BEST_LEVEL_EN
  logic [LEVEL_W-1:0]  best_level;
`endif

  modport master (
    input  go, next_signal, miss,
    output drop_pulse, speed_count, num_blocks, curr_level, game_over, win
`ifdef BEST_LEVEL_EN
    , output best_level
`endif
  );

  modport slave (
    output go, next_signal, miss,
    input  drop_pulse, speed_count, num_blocks, curr_level, game_over, win
`ifdef BEST_LEVEL_EN
    , input best_level
`endif
  );
endinterface

// File: rtl/stack_level_ctrl.sv
// Level/difficulty controller for the block stacker: go press/release -> drop,
// verdict -> advance/win/lose. Optional feature macro: BEST_LEVEL_EN (best_level).
module stack_level_ctrl #(
  parameter int unsigned MAX_LEVEL    = 15,
  parameter int unsigned LEVEL_W      = 6,
  parameter int unsigned SPEED_W      = 11,
  parameter int unsigned SPEED_START  = 60,
  parameter int unsigned SPEED_STEP   = 3,
  parameter int unsigned SPEED_MIN    = 6,
  parameter int unsigned BLOCKS_W     = 4,
  parameter int unsigned BLOCKS_START = 3,
  parameter int unsigned BLOCKS_EVERY = 5
) (
  input  logic           clk,
  input  logic           resetn,
  stack_level_if.master  bus
);

  typedef enum logic [2:0] {
    S_WAIT, S_HELD, S_JUDGE, S_WIN, S_LOSE, S_HELD_END
  } state_t;

  state_t              state_q, state_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [SPEED_W-1:0]  speed_q;
  logic [BLOCKS_W-1:0] blocks_q;
  logic                drop_q, drop_d;
  logic                over_q, over_d;
  logic                win_q, win_d;
  logic                arm_q;

  // Compare before subtracting so a steep step never wraps below the floor.
  function automatic logic [SPEED_W-1:0] sat_speed(input logic [LEVEL_W-1:0] lvl);
    int unsigned l_idx, dec;
    l_idx = 32'(lvl) - 32'd1;
    dec   = l_idx * SPEED_STEP;
    if (dec >= SPEED_START - SPEED_MIN) return SPEED_W'(SPEED_MIN);
    return SPEED_W'(SPEED_START - dec);
  endfunction

  function automatic logic [BLOCKS_W-1:0] sat_blocks(input logic [LEVEL_W-1:0] lvl);
    int unsigned l_idx, red;
    l_idx = 32'(lvl) - 32'd1;
    red   = l_idx / BLOCKS_EVERY;
    if (red >= BLOCKS_START - 1) return BLOCKS_W'(1);
    return BLOCKS_W'(BLOCKS_START - red);
  endfunction

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    drop_d  = 1'b0;
    over_d  = over_q;
    win_d   = win_q;
    case (state_q)
      S_WAIT:     if (bus.go && arm_q) state_d = S_HELD;
      S_HELD:     if (!bus.go) begin
                    state_d = S_JUDGE;
                    drop_d  = 1'b1;
                  end
      S_JUDGE:    if (bus.miss) begin
                    state_d = S_LOSE;
                    over_d  = 1'b1;
                  end else if (bus.next_signal) begin
                    if (level_q < LEVEL_W'(MAX_LEVEL)) begin
                      state_d = S_WAIT;
                      level_d = level_q + LEVEL_W'(1);
                    end else begin
                      state_d = S_WIN;
                      win_d   = 1'b1;
                    end
                  end
      S_WIN,
      S_LOSE:     if (bus.go) state_d = S_HELD_END;
      S_HELD_END: if (!bus.go) begin
                    state_d = S_WAIT;
                    level_d = LEVEL_W'(1);
                    over_d  = 1'b0;
                    win_d   = 1'b0;
                  end
      default:    state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_WAIT;
      level_q  <= LEVEL_W'(1);
      speed_q  <= SPEED_W'(SPEED_START);
      blocks_q <= BLOCKS_W'(BLOCKS_START);
      drop_q   <= 1'b0;
      over_q   <= 1'b0;
      win_q    <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      speed_q  <= sat_speed(level_d);
      blocks_q <= sat_blocks(level_d);
      drop_q   <= drop_d;
      over_q   <= over_d;
      win_q    <= win_d;
      // A go held through reset release must be seen low once before it counts.
      arm_q    <= arm_q | ~bus.go;
    end
  end

`ifdef BEST_LEVEL_EN
  logic [LEVEL_W-1:0] best_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      best_q <= '0;
    end else if (state_q == S_JUDGE && state_d == S_WIN) begin
      best_q <= LEVEL_W'(MAX_LEVEL);
    end else if (state_q == S_JUDGE && state_d == S_LOSE &&
                 (level_q - LEVEL_W'(1)) > best_q) begin
      best_q <= level_q - LEVEL_W'(1);
    end
  end

  assign bus.best_level = best_q;
`endif

  assign bus.drop_pulse  = drop_q;
  assign bus.speed_count = speed_q;
  assign bus.num_blocks  = blocks_q;
  assign bus.curr_level  = level_q;
  assign bus.game_over   = over_q;
  assign bus.win         = win_q;

endmodule

// File: tb/tb_stack_level_ctrl.sv
// Scoreboard bench for stack_level_ctrl: expected drops are queued at release
// and matched (cycle, level, speed, blocks) when the DUT pulses drop_pulse.
module tb_stack_level_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic go = 1'b0, nxt = 1'b0, miss = 1'b0;
  int   cyc = 0;
  int   n_chk = 0, n_err = 0;

  typedef struct { int cyc; int lvl; } drop_t;
  drop_t drop_sb[$];
  drop_t exp_drop;

  stack_level_if bus ();
  stack_level_if bus2 ();

  assign bus.go           = go;
  assign bus.next_signal  = nxt;
  assign bus.miss         = miss;
  assign bus2.go          = go;
  assign bus2.next_signal = nxt;
  assign bus2.miss        = miss;

  stack_level_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));
  stack_level_ctrl #(.SPEED_STEP(10)) dut_steep (.clk(clk), .resetn(resetn), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference: step down one level at a time, clamping at the floor.
  function automatic int ref_speed(input int lvl, input int step);
    int s = 60;
    for (int i = 1; i < lvl; i++) s = (s >= 6 + step) ? s - step : 6;
    return s;
  endfunction

  function automatic int ref_blocks(input int lvl);
    int b = 3;
    for (int i = 1; i < lvl; i++) if (i % 5 == 0 && b > 1) b--;
    return b;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hold, input bit want_drop, input int lvl);
    drop_t d;
    go = 1'b1;
    tick(hold);
    go = 1'b0;
    if (want_drop) begin
      d.cyc = cyc + 1;
      d.lvl = lvl;
      drop_sb.push_back(d);
    end
    tick(1);
  endtask

  task automatic succeed();
    nxt = 1'b1;
    tick(1);
    nxt = 1'b0;
  endtask

  task automatic play(input int lvl);
    press(2, 1'b1, lvl);
    succeed();
  endtask

  always @(negedge clk) begin
    if (resetn && bus.drop_pulse) begin
      if (drop_sb.size() == 0) begin
        check("drop_unexpected", 32'd1, 32'd0);
      end else begin
        exp_drop = drop_sb.pop_front();
        check("drop_cycle",  32'(cyc), 32'(exp_drop.cyc));
        check("drop_level",  32'(bus.curr_level), 32'(exp_drop.lvl));
        check("drop_speed",  32'(bus.speed_count), 32'(ref_speed(exp_drop.lvl, 3)));
        check("drop_blocks", 32'(bus.num_blocks), 32'(ref_blocks(exp_drop.lvl)));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycles %0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_level",  32'(bus.curr_level), 32'd1);
    check("rst_speed",  32'(bus.speed_count), 32'd60);
    check("rst_blocks", 32'(bus.num_blocks), 32'd3);
    check("rst_drop",   32'(bus.drop_pulse), 32'd0);
    check("rst_over",   32'(bus.game_over), 32'd0);
    check("rst_win",    32'(bus.win), 32'd0);
`ifdef BEST_LEVEL_EN
    check("rst_best",   32'(bus.best_level), 32'd0);
`endif
    @(posedge clk); #1;
    resetn = 1'b1;
    tick(2);

    // Level 1: long press, then linger in JUDGE (no timeout), then succeed.
    press(3, 1'b1, 1);
    tick(4);
    check("judge_wait_level", 32'(bus.curr_level), 32'd1);
    succeed();
    check("adv_level2", 32'(bus.curr_level), 32'd2);
    check("adv_speed2", 32'(bus.speed_count), 32'd57);

    // Verdicts outside JUDGE are ignored.
    succeed();
    miss = 1'b1; tick(1); miss = 1'b0;
    check("ign_next_level", 32'(bus.curr_level), 32'd2);
    check("ign_miss_over",  32'(bus.game_over), 32'd0);

    play(2);
    play(3);
    press(2, 1'b1, 4);
    miss = 1'b1; nxt = 1'b1; tick(1); miss = 1'b0; nxt = 1'b0;
    check("lose_over",  32'(bus.game_over), 32'd1);
    check("lose_win",   32'(bus.win), 32'd0);
    check("lose_level", 32'(bus.curr_level), 32'd4);
`ifdef BEST_LEVEL_EN
    check("lose_best",  32'(bus.best_level), 32'd3);
`endif

    // Restart from LOSE: no drop expected for this press.
    press(3, 1'b0, 0);
    check("rst_game_over", 32'(bus.game_over), 32'd0);
    check("rst_game_lvl",  32'(bus.curr_level), 32'd1);
    check("rst_game_spd",  32'(bus.speed_count), 32'd60);
    tick(2);

    for (int l = 1; l < 15; l++) begin
      play(l);
      if (l + 1 == 6) begin
        check("lvl6_speed",  32'(bus.speed_count), 32'd45);
        check("lvl6_blocks", 32'(bus.num_blocks), 32'd2);
      end
      if (l + 1 == 7) check("steep_lvl7_speed", 32'(bus2.speed_count), 32'd6);
      if (l + 1 == 11) check("lvl11_blocks", 32'(bus.num_blocks), 32'd1);
    end
    press(2, 1'b1, 15);
    succeed();
    check("win_win",    32'(bus.win), 32'd1);
    check("win_over",   32'(bus.game_over), 32'd0);
    check("win_level",  32'(bus.curr_level), 32'd15);
    check("win_speed",  32'(bus.speed_count), 32'd18);
    check("win_blocks", 32'(bus.num_blocks), 32'd1);
    check("steep_win_speed", 32'(bus2.speed_count), 32'd6);
`ifdef BEST_LEVEL_EN
    check("win_best",   32'(bus.best_level), 32'd15);
`endif

    go = 1'b1; tick(2);
    check("held_end_win", 32'(bus.win), 32'd1);
    go = 1'b0; tick(1);
    check("restart_win",   32'(bus.win), 32'd0);
    check("restart_level", 32'(bus.curr_level), 32'd1);
    check("restart_speed", 32'(bus.speed_count), 32'd60);
    tick(2);

    // Async reset in JUDGE at level 5 with go held.
    for (int l = 1; l < 5; l++) play(l);
    press(2, 1'b1, 5);
    go = 1'b1;
    tick(1);
    #3 resetn = 1'b0;
    #1;
    check("async_level",  32'(bus.curr_level), 32'd1);
    check("async_speed",  32'(bus.speed_count), 32'd60);
    check("async_blocks", 32'(bus.num_blocks), 32'd3);
    check("async_drop",   32'(bus.drop_pulse), 32'd0);
`ifdef BEST_LEVEL_EN
    check("async_best",   32'(bus.best_level), 32'd0);
`endif
    @(posedge clk); #1;
    resetn = 1'b1;
    tick(4);
    go = 1'b0;
    tick(3);
    check("held_go_level", 32'(bus.curr_level), 32'd1);
    press(2, 1'b1, 1);
    tick(3);
    check("pending_drops", 32'(drop_sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
